// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the memory/write-back stage: access sizes and FSM states.
package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wb_stage_if.sv
// Pipeline-side, data-memory and write-back signals of the MEM stage bundled together.
interface mem_wb_stage_if;

  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_rd;
  logic [1:0]  mem_size;
  logic        mem_load;
  logic        mem_store;
  logic        mem_rf_en;
  logic        mem_signed;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  logic        mem_stall;
  logic [31:0] wb_data;
  logic [3:0]  wb_rd;
  logic        wb_rf_en;
  logic        mem_fault;

  // The stage itself
  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_rd, mem_size,
           mem_load, mem_store, mem_rf_en, mem_signed,
           dmem_rdata, dmem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           mem_stall, wb_data, wb_rd, wb_rf_en, mem_fault
  );

  // Surrounding pipeline and data memory
  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_rd, mem_size,
           mem_load, mem_store, mem_rf_en, mem_signed,
           dmem_rdata, dmem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           mem_stall, wb_data, wb_rd, wb_rf_en, mem_fault
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for stores and lane extraction for loads.
// MEM_SIGN_EXT_EN: when defined, signed sub-word loads are sign-extended.
module mem_lane_align
  import mem_wb_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  input  logic        sgn,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ext_b;
  logic        ext_h;

  assign ld_byte = ld_raw[{offset, 3'b000} +: 8];
  assign ld_half = offset[1] ? ld_raw[31:16] : ld_raw[15:0];

`ifdef MEM_SIGN_EXT_EN
  assign ext_b = sgn & ld_byte[7];
  assign ext_h = sgn & ld_half[15];
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign ext_b      = 1'b0;
  assign ext_h      = 1'b0;
`endif

  // Size 2'b11 falls through to the word case
  always_comb begin
    be       = 4'hF;
    st_lanes = st_data;
    ld_data  = ld_raw;
    case (size_e'(size))
      SZ_BYTE: begin
        be       = 4'b0001 << offset;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = {{24{ext_b}}, ld_byte};
      end
      SZ_HALF: begin
        be       = offset[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
        ld_data  = {{16{ext_h}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: handshaked data-memory access with timeout, upstream stall, and MEM/WB register.
// MEM_SIGN_EXT_EN (in mem_lane_align) enables sign-extension of signed sub-word loads.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic          clk,
  input  logic          reset,
  mem_wb_stage_if.slave bus
);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             expired;
  logic             done;
  logic [31:0]      rdata_eff;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata;
  logic [31:0]      lane_rdata;

  assign access    = bus.mem_valid && (bus.mem_load || bus.mem_store);
  assign expired   = (cnt == CNT_W'(TIMEOUT - 1));
  assign done      = (state == ST_BUSY) && (bus.dmem_ack || expired);
  // A timed-out access completes with zero read data
  assign rdata_eff = bus.dmem_ack ? bus.dmem_rdata : 32'h0;

  // Upstream is stalled, so mem_* still describe the in-flight access while BUSY
  mem_lane_align u_align (
    .size     (bus.mem_size),
    .offset   (bus.mem_addr[1:0]),
    .st_data  (bus.mem_wdata),
    .ld_raw   (rdata_eff),
    .sgn      (bus.mem_signed),
    .be       (lane_be),
    .st_lanes (lane_wdata),
    .ld_data  (lane_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.mem_stall = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          state_nxt     = ST_BUSY;
          bus.mem_stall = 1'b1;
        end
      end
      ST_BUSY: begin
        bus.mem_stall = !bus.dmem_ack && !expired;
        if (done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= 32'h0;
      bus.dmem_be    <= 4'h0;
      bus.dmem_wdata <= 32'h0;
      bus.wb_data    <= 32'h0;
      bus.wb_rd      <= 4'h0;
      bus.wb_rf_en   <= 1'b0;
      bus.mem_fault  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            cnt            <= '0;
            bus.dmem_req   <= 1'b1;
            bus.dmem_we    <= bus.mem_store && !bus.mem_load;
            bus.dmem_addr  <= {bus.mem_addr[31:2], 2'b00};
            bus.dmem_be    <= lane_be;
            bus.dmem_wdata <= lane_wdata;
            bus.wb_rf_en   <= 1'b0;
          end else begin
            bus.wb_rf_en <= bus.mem_valid && bus.mem_rf_en;
            if (bus.mem_valid) begin
              bus.wb_data <= bus.mem_addr;
              bus.wb_rd   <= bus.mem_rd;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt + CNT_W'(1);
          if (done) begin
            bus.dmem_req <= 1'b0;
            bus.wb_rd    <= bus.mem_rd;
            bus.wb_rf_en <= bus.mem_rf_en && bus.mem_load;
            bus.wb_data  <= bus.mem_load ? lane_rdata : bus.mem_addr;
            if (!bus.dmem_ack) bus.mem_fault <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory-access stage of the 5-stage pipeline. It sits between the EXE/MEM pipeline register and the register-file write port, and drives a handshaked data-memory port for loads and stores. It performs byte-lane alignment and stalls upstream stages while an access is pending. It also contains the MEM/WB pipeline register that supplies the write-back data, WB_Rd and WB_RF_enable to the register file and the hazard/forwarding unit.

Parameters:
TIMEOUT, 16, max cycles in BUSY waiting for dmem_ack before the access is aborted (must be ≥2)
CNT_W, 5, width of wait counter; must hold TIMEOUT

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high reset
mem_valid  in  1  EXE/MEM holds a real instruction (0 = bubble)
mem_addr  in  32  ALU/SSE result: effective address or ALU data
mem_wdata  in  32  store data (DataMemIn)
mem_rd  in  4  destination register
mem_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
mem_load  in  1  load instruction
mem_store  in  1  store instruction
mem_rf_en  in  1  instruction writes Rd
mem_signed  in  1  signed load (used only with MEM_SIGN_EXT_EN)
dmem_req  out  1  memory request, held until ack
dmem_we  out  1  1 = write
dmem_addr  out  32  word-aligned address {mem_addr[31:2],2'b00}
dmem_be  out  4  byte enables, little-endian
dmem_wdata  out  32  store data replicated onto the addressed lanes
dmem_rdata  in  32  read data, valid with dmem_ack
dmem_ack  in  1  access complete, one-cycle pulse
mem_stall  out  1  hold PC, IF/ID, ID/EXE and EXE/MEM
wb_data  out  32  write-back value
wb_rd  out  4  write-back register
wb_rf_en  out  1  register-file write enable
mem_fault  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (synchronous): state=IDLE, counter=0, dmem_req=0, dmem_we=0, dmem_be=0, wb_data=0, wb_rd=0, wb_rf_en=0, mem_fault=0.
- FSM states: IDLE, BUSY.
- IDLE, with mem_valid and no load/store: the MEM/WB register loads on the next edge. wb_data=mem_addr, wb_rd=mem_rd, wb_rf_en=mem_rf_en. Latency 1, no stall.
- IDLE, with mem_valid and (mem_load or mem_store): mem_stall=1 combinationally. On the next edge: state→BUSY, dmem_req=1, dmem_we=mem_store, dmem_addr/dmem_be/dmem_wdata registered, counter=0, wb_rf_en=0 (bubble).
- If mem_load and mem_store are both high, it is treated as a load.
- BUSY: dmem_req stays 1 and the request signals are held stable. mem_stall = !dmem_ack and counter != TIMEOUT-1. The counter increments each cycle.
- BUSY with dmem_ack: dmem_req drops on the next edge and state→IDLE. The MEM/WB register loads on the same edge with wb_rf_en = mem_rf_en & mem_load. For a load, wb_data = extracted read data; for a store, wb_data = mem_addr. A memory access takes at least 2 cycles.
- BUSY timeout (counter==TIMEOUT-1 and no ack): the access completes as if acked with read data 0, and mem_fault sets.
- An ack arriving in IDLE is ignored.
- Lane rules:
  - Byte: be=1<<addr[1:0]; wdata={4{wdata[7:0]}}; load = rdata byte addr[1:0], zero-extended.
  - Halfword: addr[0] is ignored; be=addr[1]?1100:0011; wdata={2{wdata[15:0]}}; load = half addr[1], zero-extended.
  - Word: be=1111; addr[1:0] is ignored.
- mem_valid=0 in IDLE: wb_rf_en=0 on the next edge; wb_data and wb_rd are don't-care but hold.
- Reset in BUSY: dmem_req=0 on that edge, the in-flight ack is discarded, and there is no write-back.

Optional Feature:
MEM_SIGN_EXT_EN
- Defined: byte and halfword loads with mem_signed=1 are sign-extended from bit 7 or bit 15.
- Undefined: mem_signed is ignored and all sub-word loads are zero-extended.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and FSM state encodings (ST_IDLE, ST_BUSY).
- One sub-module, mem_lane_align: combinational. Takes size, addr[1:0], store data, read data and signed; produces be, replicated wdata and extracted load data.
- The FSM and the MEM/WB register stay in mem_wb_stage.

Test Plan:
- ALU pass-through: valid, addr=0x1234, rd=3, rf_en=1, no load/store → next cycle wb_data=0x1234, wb_rd=3, wb_rf_en=1, mem_stall never high.
- Word load with 3-cycle ack: addr=0x100 → dmem_req high for 3 cycles, dmem_addr=0x100, be=1111, dmem_we=0; rdata=0xDEADBEEF → wb_data=0xDEADBEEF, wb_rf_en=1; mem_stall high for 3 cycles.
- Byte store: addr=0x203, wdata=0x000000A5 → be=1000, dmem_wdata=0xA5A5A5A5, dmem_we=1; wb_rf_en=0 after ack.
- Halfword load: addr=0x302, rdata=0x8001FFFF, mem_signed=1 → wb_data=0xFFFF8001 with MEM_SIGN_EXT_EN, 0x00008001 without.
- Timeout: TIMEOUT=4, ack never asserted → after 4 BUSY cycles state=IDLE, wb_data=0, mem_fault=1 and stays 1 until reset.
- Reset while BUSY: assert reset in the 2nd BUSY cycle, then ack one cycle later → dmem_req=0 after the reset edge, wb_rf_en stays 0, the ack is ignored.
